// File: rtl/ember_l2_pkg.sv
// Shared types and elaboration-time helpers for the Ember cluster L2 window controller.
package ember_l2_pkg;

  typedef enum logic [1:0] {IDLE, REQ, FILL, SERVE} state_t;

  function automatic int log2_of(input int v);
    return $clog2(v);
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int width_of(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int wb_bytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int n_cores, input int addr_w, input int data_w,
                                   input int win_words, input int burst_beats);
    return (n_cores >= 1) && (data_w >= 8) && is_pow2(data_w) &&
           (win_words >= 2) && is_pow2(win_words) &&
           is_pow2(burst_beats) && (burst_beats <= win_words) &&
           (log2_of(win_words * wb_bytes(data_w)) < addr_w);
  endfunction

endpackage

// File: rtl/l2_window_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, searching circularly.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             valid,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr) + i) % N;
      if (valid && req[j] && (grant == '0)) begin
        grant[j] = 1'b1;
        idx      = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/l2_window_arbiter.sv
// Shared-L2 window controller: round-robin core arbitration, wrapping read bursts
// from one aligned window, and whole-window refill over the ring on a tag miss.
module l2_window_arbiter
  import ember_l2_pkg::*;
#(
  parameter int N_CORES     = 4,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int WIN_WORDS   = 16,
  parameter int BURST_BEATS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CORES-1:0]          core_req,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  output logic [N_CORES-1:0]          core_gnt,
  output logic [N_CORES-1:0]          core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        core_rlast,
  output logic                        ring_req,
  output logic [ADDR_W-1:0]           ring_addr,
  input  logic                        ring_ack,
  input  logic                        ring_rvalid,
  input  logic [DATA_W-1:0]           ring_rdata,
  output logic                        window_valid,
  output logic [ADDR_W-1:0]           window_base
);

  localparam int WB        = wb_bytes(DATA_W);
  localparam int WIN_BYTES = WIN_WORDS * WB;
  localparam int WB_SHIFT  = log2_of(WB);
  localparam int WIN_SHIFT = log2_of(WIN_BYTES);
  localparam int IDX_W     = log2_of(WIN_WORDS);
  localparam int PTR_W     = width_of(N_CORES);
  localparam int BEAT_W    = width_of(BURST_BEATS);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(WIN_BYTES - 1);

  if (!params_ok(N_CORES, ADDR_W, DATA_W, WIN_WORDS, BURST_BEATS)) begin : g_bad_params
    $error("l2_window_arbiter: illegal parameter combination");
  end

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    rr_ptr;
  logic [N_CORES-1:0]  arb_grant;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_any;
  logic [ADDR_W-1:0]   win_addr;
  logic                hit;
  logic [ADDR_W-1:0]   addr_q;
  logic [N_CORES-1:0]  sel_gnt;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    fill_idx;
  logic [BEAT_W-1:0]   beat;
  logic                fill_last;
  logic [DATA_W-1:0]   mem [WIN_WORDS];

  rr_arbiter #(.N(N_CORES), .PTR_W(PTR_W)) u_arb (
    .req   (core_req),
    .ptr   (rr_ptr),
    .valid (state == IDLE),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign arb_any   = |arb_grant;
  assign win_addr  = core_addr[arb_idx*ADDR_W +: ADDR_W];
  assign hit       = window_valid && ((win_addr >> WIN_SHIFT) == (window_base >> WIN_SHIFT));
  assign fill_last = ring_rvalid && (fill_idx == IDX_W'(WIN_WORDS - 1));
  assign ring_req  = (state == REQ);
  assign ring_addr = addr_q & ~OFS_MASK;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_any) state_nxt = hit ? SERVE : REQ;
      REQ:     if (ring_ack) state_nxt = FILL;
      FILL:    if (fill_last) state_nxt = SERVE;
      SERVE:   if (beat == BEAT_W'(BURST_BEATS - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      core_gnt     <= '0;
      core_rvalid  <= '0;
      core_rdata   <= '0;
      core_rlast   <= 1'b0;
      window_valid <= 1'b0;
      window_base  <= '0;
      addr_q       <= '0;
      sel_gnt      <= '0;
      rd_idx       <= '0;
      fill_idx     <= '0;
      beat         <= '0;
    end else begin
      state       <= state_nxt;
      core_gnt    <= '0;
      core_rvalid <= '0;
      core_rlast  <= 1'b0;
      case (state)
        IDLE: if (arb_any) begin
          core_gnt <= arb_grant;
          sel_gnt  <= arb_grant;
          addr_q   <= win_addr;
          rd_idx   <= IDX_W'(win_addr >> WB_SHIFT);
          beat     <= '0;
          rr_ptr   <= (arb_idx == PTR_W'(N_CORES - 1)) ? '0 : arb_idx + 1'b1;
        end
        REQ: if (ring_ack) begin
          window_valid <= 1'b0;
          fill_idx     <= '0;
        end
        FILL: if (ring_rvalid) begin
          fill_idx <= fill_idx + 1'b1;
          if (fill_last) begin
            window_valid <= 1'b1;
            window_base  <= addr_q & ~OFS_MASK;
          end
        end
        SERVE: begin
          // rd_idx wraps at the window size, giving the in-window burst wrap.
          core_rvalid <= sel_gnt;
          core_rdata  <= mem[rd_idx];
          core_rlast  <= (beat == BEAT_W'(BURST_BEATS - 1));
          rd_idx      <= rd_idx + 1'b1;
          beat        <= beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the window array has no reset; window_valid alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (!rst && (state == FILL) && ring_rvalid) mem[fill_idx] <= ring_rdata;
  end

endmodule

// File: tb/tb_l2_window_arbiter.sv
// Scoreboard bench for l2_window_arbiter: directed requests push expected grants and beats,
// a monitor pops and compares whenever the DUT pulses core_gnt or core_rvalid.
module tb_l2_window_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   core_req = '0;
  logic [255:0] core_addr = '0;
  logic [3:0]   core_gnt, core_rvalid;
  logic [63:0]  core_rdata;
  logic         core_rlast;
  logic         ring_req;
  logic [63:0]  ring_addr;
  logic         ring_ack = 1'b0;
  logic         ring_rvalid = 1'b0;
  logic [63:0]  ring_rdata = '0;
  logic         window_valid;
  logic [63:0]  window_base;

  l2_window_arbiter #(.N_CORES(4), .ADDR_W(64), .DATA_W(64), .WIN_WORDS(16), .BURST_BEATS(4)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_addr(core_addr),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .core_rlast(core_rlast), .ring_req(ring_req), .ring_addr(ring_addr),
    .ring_ack(ring_ack), .ring_rvalid(ring_rvalid), .ring_rdata(ring_rdata),
    .window_valid(window_valid), .window_base(window_base)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_gnt[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int core, input int start);
    for (int b = 0; b < 4; b++) begin
      beat_t e;
      e.core = core;
      e.data = 64'h1000 + 64'((start + b) % 16);
      e.last = (b == 3);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (core_gnt != 4'b0) begin
          if (exp_gnt.size() == 0) check("gnt_unexpected", 64'(core_gnt), 64'(0));
          else begin
            int g;
            g = exp_gnt.pop_front();
            check("gnt_core", 64'(core_gnt), 64'(4'b0001 << g));
          end
        end
        if (core_rvalid != 4'b0) begin
          if (exp_q.size() == 0) check("rvalid_unexpected", 64'(core_rvalid), 64'(0));
          else begin
            beat_t e;
            e = exp_q.pop_front();
            check("rvalid_core", 64'(core_rvalid), 64'(4'b0001 << e.core));
            check("rdata", core_rdata, e.data);
            check("rlast", 64'(core_rlast), 64'(e.last));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Raise a request and hold it until the grant is seen; returns on the grant negedge.
  task automatic do_request(input int core, input logic [63:0] addr);
    bit found;
    found = 1'b0;
    core_addr[core*64 +: 64] = addr;
    core_req[core] = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (core_gnt[core]) found = 1'b1;
    end
    core_req[core] = 1'b0;
    check("gnt_wait", 64'(found), 64'(1));
  endtask

  // Answer a ring refill: hold off ack for 'delay' cycles, then stream 'beats' words.
  task automatic ring_serve(input int delay, input int beats, input logic [63:0] exp_addr);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (ring_req) found = 1'b1;
    end
    check("ring_req_wait", 64'(found), 64'(1));
    check("ring_addr", ring_addr, exp_addr);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check("ring_req_hold", 64'(ring_req), 64'(1));
      check("ring_addr_hold", ring_addr, exp_addr);
    end
    ring_ack = 1'b1;
    @(negedge clk);
    ring_ack = 1'b0;
    check("window_valid_fill", 64'(window_valid), 64'(0));
    for (int i = 0; i < beats; i++) begin
      ring_rvalid = 1'b1;
      ring_rdata  = 64'h1000 + 64'(i);
      @(negedge clk);
    end
    ring_rvalid = 1'b0;
    ring_rdata  = '0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_gnt.size() == 0) done = 1'b1;
    end
    check("drain_wait", 64'(done), 64'(1));
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 64'(core_gnt), 64'(0));
    check({tag, "_rvalid"}, 64'(core_rvalid), 64'(0));
    check({tag, "_rdata"}, core_rdata, 64'(0));
    check({tag, "_rlast"}, 64'(core_rlast), 64'(0));
    check({tag, "_ring_req"}, 64'(ring_req), 64'(0));
    check({tag, "_ring_addr"}, ring_addr, 64'(0));
    check({tag, "_wvalid"}, 64'(window_valid), 64'(0));
    check({tag, "_wbase"}, window_base, 64'(0));
  endtask

  initial begin
    int n;
    int last_cyc;

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Cold miss: core0 @0x40 -> words 8..11 after a full refill of window 0x0.
    exp_gnt.push_back(0);
    push_burst(0, 8);
    do_request(0, 64'h40);
    ring_serve(0, 16, 64'h0);
    wait_drain();
    check("cold_wvalid", 64'(window_valid), 64'(1));
    check("cold_wbase", window_base, 64'h0);

    // Hit with wrap: core1 @0x78 -> words 15,0,1,2, data one cycle after gnt.
    exp_gnt.push_back(1);
    push_burst(1, 15);
    do_request(1, 64'h78);
    check("hit_no_ring_req", 64'(ring_req), 64'(0));
    @(negedge clk);
    check("hit_latency", 64'(core_rvalid), 64'(4'b0010));
    wait_drain();

    // Fairness from rr_ptr=2 with all cores requesting hits continuously.
    core_addr[0*64 +: 64] = 64'h00;
    core_addr[1*64 +: 64] = 64'h20;
    core_addr[2*64 +: 64] = 64'h48;
    core_addr[3*64 +: 64] = 64'h70;
    exp_gnt.push_back(2); push_burst(2, 9);
    exp_gnt.push_back(3); push_burst(3, 14);
    exp_gnt.push_back(0); push_burst(0, 0);
    exp_gnt.push_back(1); push_burst(1, 4);
    exp_gnt.push_back(2); push_burst(2, 9);
    core_req = 4'hF;
    n = 0;
    last_cyc = 0;
    for (int k = 0; k < 100 && n < 5; k++) begin
      @(negedge clk);
      if (core_gnt != 4'b0) begin
        if (n > 0) check("rr_spacing", 64'(cyc - last_cyc), 64'(5));
        last_cyc = cyc;
        n++;
      end
    end
    core_req = 4'h0;
    check("rr_grants", 64'(n), 64'(5));
    wait_drain();

    // Replacement with slow ack: core3 @0x108 -> window 0x100, first beat word 1.
    exp_gnt.push_back(3);
    push_burst(3, 1);
    do_request(3, 64'h108);
    ring_serve(3, 16, 64'h100);
    wait_drain();
    check("repl_wvalid", 64'(window_valid), 64'(1));
    check("repl_wbase", window_base, 64'h100);

    // Reset after 5 fill beats abandons the refill; the same request refetches fully.
    exp_gnt.push_back(0);
    do_request(0, 64'h40);
    ring_serve(0, 5, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midfill");
    rst = 1'b0;
    exp_gnt.push_back(0);
    push_burst(0, 8);
    do_request(0, 64'h40);
    ring_serve(0, 16, 64'h0);
    wait_drain();
    check("refetch_wbase", window_base, 64'h0);

    // Stray ring traffic in IDLE and SERVE must change nothing.
    ring_rvalid = 1'b1;
    ring_ack    = 1'b1;
    ring_rdata  = 64'hDEAD_BEEF_0000_0000;
    repeat (3) begin
      @(negedge clk);
      check("stray_ring_req", 64'(ring_req), 64'(0));
      check("stray_rvalid", 64'(core_rvalid), 64'(0));
      check("stray_wvalid", 64'(window_valid), 64'(1));
    end
    exp_gnt.push_back(2);
    push_burst(2, 2);
    do_request(2, 64'h10);
    wait_drain();
    ring_rvalid = 1'b0;
    ring_ack    = 1'b0;
    ring_rdata  = '0;
    exp_gnt.push_back(1);
    push_burst(1, 0);
    do_request(1, 64'h00);
    wait_drain();
    check("stray_wbase", window_base, 64'h0);

    check("leftover_beats", 64'(exp_q.size()), 64'(0));
    check("leftover_gnts", 64'(exp_gnt.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
